// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters, the mux4_rr_arbiter and its downstream consumer.
// The slave modport is the arbiter side; the master modport is the requester/consumer side.
interface mux4_rr_arbiter_if #(
  parameter int unsigned W = 8
);
  logic [4*W-1:0] In;
  logic [3:0]     ReqValid;
  logic [3:0]     ReqReady;
  logic [1:0]     S;
  logic [W-1:0]   Out;
  logic           OutValid;
  logic           OutReady;
  logic           Busy;

  modport master (
    output In, ReqValid, OutReady,
    input  ReqReady, S, Out, OutValid, Busy
  );

  modport slave (
    input  In, ReqValid, OutReady,
    output ReqReady, S, Out, OutValid, Busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin, burst-bounded arbiter driving a 4:1 mux select plus one registered output stage.
// Define MUX4_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest, no rotating pointer).
module mux4_rr_arbiter #(
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input logic              Clk,
  input logic              Rst,
  mux4_rr_arbiter_if.slave bus
);

  localparam logic [3:0] BEAT_LAST = 4'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_s;
  logic [3:0]   r_beats;
  logic [W-1:0] r_out;
  logic         r_out_valid;
  logic         r_busy;

  logic [1:0]   w_base;
  logic [1:0]   w_winner;
  logic         w_any_req;
  logic         w_req_cur;
  logic         w_rdy;
  logic         w_grant;
  logic         w_xfer;
  logic         w_release;
  logic [3:0]   w_req_ready;
  logic [W-1:0] w_lane;

`ifdef MUX4_ARB_FIXED_PRIO_EN
  assign w_base = 2'd0;
`else
  logic [1:0] r_ptr;

  // Priority rotates to the requester after the one just released
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ptr <= 2'd0;
    end else if (w_release) begin
      r_ptr <= r_s + 2'd1;
    end
  end

  assign w_base = r_ptr;
`endif

  assign w_any_req = |bus.ReqValid;
  assign w_req_cur = bus.ReqValid[r_s];

  // First valid requester scanning base, base+1, ... mod 4
  always_comb begin
    logic [1:0] idx;
    logic       found;
    w_winner = 2'd0;
    found    = 1'b0;
    idx      = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = w_base + 2'(i);
      if (!found && bus.ReqValid[idx]) begin
        w_winner = idx;
        found    = 1'b1;
      end
    end
  end

  // Mux tree lane selected by the registered select
  always_comb begin
    w_lane = bus.In[0 +: W];
    case (r_s)
      2'd1:    w_lane = bus.In[W +: W];
      2'd2:    w_lane = bus.In[2*W +: W];
      2'd3:    w_lane = bus.In[3*W +: W];
      default: w_lane = bus.In[0 +: W];
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant)   w_state_nxt = GRANT;
      GRANT:   if (w_release) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ready follows OutReady combinationally so a drain and a load can share one cycle
  always_comb begin
    w_req_ready = 4'd0;
    w_grant     = 1'b0;
    w_xfer      = 1'b0;
    w_release   = 1'b0;
    w_rdy       = !r_out_valid || bus.OutReady;
    case (r_state)
      IDLE: begin
        w_grant = w_any_req;
      end
      GRANT: begin
        w_req_ready[r_s] = w_rdy;
        w_xfer           = w_req_cur && w_rdy;
        w_release        = (w_xfer && (r_beats == BEAT_LAST)) || !w_req_cur;
      end
      default: begin
        w_grant = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s         <= 2'd0;
      r_beats     <= 4'd0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == GRANT);
      if (w_grant) begin
        r_s     <= w_winner;
        r_beats <= 4'd0;
      end else if (w_xfer) begin
        r_beats <= r_beats + 4'd1;
      end
      if (w_xfer) begin
        r_out       <= w_lane;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && bus.OutReady) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.ReqReady = w_req_ready;
  assign bus.S        = r_s;
  assign bus.Out      = r_out;
  assign bus.OutValid = r_out_valid;
  assign bus.Busy     = r_busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: transaction-level arbitration model checked every cycle,
// plus directed scenarios with literal expectations (reset, single, fairness, backpressure, release, abort).
module tb_mux4_rr_arbiter;

  localparam int unsigned W         = 8;
  localparam int unsigned MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmp_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mux4_rr_arbiter_if #(.W(W)) bus ();

  mux4_rr_arbiter #(.W(W), .MAX_BURST(MAX_BURST)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lane(input int k, input logic [W-1:0] v);
    bus.In[k*W +: W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Model: who owns the channel, how many words it has moved, whose turn is next,
  // and the single word (if any) sitting in the output stage.
  int           m_owner = -1;
  int           m_beats = 0;
  int           m_prio  = 0;
  logic [1:0]   m_s     = 2'd0;
  logic [W-1:0] m_out   = '0;
  bit           m_full  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_beats = 0; m_prio = 0; m_s = 2'd0; m_out = '0; m_full = 1'b0;
    end else if (m_owner < 0) begin
      if (m_full && bus.OutReady) m_full = 1'b0;
      if (bus.ReqValid != 4'd0) begin
        int base;
`ifdef MUX4_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = m_prio;
`endif
        for (int i = 3; i >= 0; i--)
          if (bus.ReqValid[(base + i) % 4]) m_owner = (base + i) % 4;
        m_s     = 2'(m_owner);
        m_beats = 0;
      end
    end else begin
      if (bus.ReqValid[m_owner] && (!m_full || bus.OutReady)) begin
        m_out  = bus.In[m_owner*W +: W];
        m_full = 1'b1;
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_prio  = (m_owner + 1) % 4;
          m_owner = -1;
        end
      end else begin
        if (m_full && bus.OutReady) m_full = 1'b0;
        if (!bus.ReqValid[m_owner]) begin
          m_prio  = (m_owner + 1) % 4;
          m_owner = -1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0] exp_rr;
      exp_rr = 4'd0;
      if (m_owner >= 0 && (!m_full || bus.OutReady)) exp_rr[m_owner] = 1'b1;
      chk("cyc_req_ready", 32'(bus.ReqReady), 32'(exp_rr));
      chk("cyc_s",         32'(bus.S),        32'(m_s));
      chk("cyc_out_valid", 32'(bus.OutValid), 32'(m_full));
      chk("cyc_out",       32'(bus.Out),      32'(m_out));
      chk("cyc_busy",      32'(bus.Busy),     32'(m_owner >= 0));
    end
  end

  // Observed grant sequence and delivered words
  int         glog[$];
  logic [W-1:0] rx[$];
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    if (bus.Busy === 1'b1 && !prev_busy) glog.push_back(int'(bus.S));
    prev_busy = (bus.Busy === 1'b1);
    if (!rst && bus.OutValid === 1'b1 && bus.OutReady) rx.push_back(bus.Out);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rr_order[5];
`ifdef MUX4_ARB_FIXED_PRIO_EN
    exp_rr_order = '{0, 0, 0, 0, 0};
`else
    exp_rr_order = '{0, 1, 2, 3, 0};
`endif

    // Reset with every requester asserting
    rst = 1'b1; bus.ReqValid = 4'hF; bus.OutReady = 1'b1;
    bus.In = {8'h33, 8'h22, 8'h11, 8'h00};
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.ReqReady), 32'h0);
    chk("rst_out_valid", 32'(bus.OutValid), 32'h0);
    chk("rst_out",       32'(bus.Out),      32'h0);
    chk("rst_s",         32'(bus.S),        32'h0);
    chk("rst_busy",      32'(bus.Busy),     32'h0);
    @(posedge clk); #1;

    // Single requester on lane 2
    glog.delete();
    bus.ReqValid = 4'b0100; set_lane(2, 8'hA5); rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_s",         32'(bus.S),        32'd2);
    chk("single_busy",      32'(bus.Busy),     32'd1);
    chk("single_req_ready", 32'(bus.ReqReady), 32'b0100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_out",       32'(bus.Out),      32'hA5);
    chk("single_out_valid", 32'(bus.OutValid), 32'd1);
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    chk("single_bubble_busy", 32'(bus.Busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_regrant_busy", 32'(bus.Busy), 32'd1);
    chk("single_regrant_s",    32'(bus.S),    32'd2);
    @(posedge clk); #1;
    bus.ReqValid = 4'b0000;
    repeat (2) @(posedge clk); #1;
    chk("single_grant_count", 32'(glog.size()), 32'd2);

    // Fairness with all four requesters continuously valid
    bus.ReqValid = 4'hF; bus.OutReady = 1'b1;
    bus.In = {8'h43, 8'h42, 8'h41, 8'h40};
    do_reset();
    glog.delete();
    repeat (24) @(posedge clk); #1;
    for (int i = 0; i < 5; i++)
      chk("rr_order", (glog.size() > i) ? 32'(glog[i]) : 32'hFFFF_FFFF, 32'(exp_rr_order[i]));
    bus.ReqValid = 4'b0000;

    // Backpressure during a grant to requester 1
    bus.ReqValid = 4'b0010; set_lane(1, 8'h10); bus.OutReady = 1'b1;
    do_reset();
    rx.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_before", 32'(bus.ReqReady), 32'b0010);
    @(posedge clk); #1;
    set_lane(1, 8'h11); bus.OutReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready_held", 32'(bus.ReqReady), 32'h0);
      chk("bp_out_stable", 32'(bus.Out),      32'h10);
      @(posedge clk); #1;
    end
    bus.OutReady = 1'b1;
    @(posedge clk); #1;
    set_lane(1, 8'h12);
    @(posedge clk); #1;
    bus.ReqValid = 4'b0000;
    repeat (3) @(posedge clk); #1;
    chk("bp_rx_count", 32'(rx.size()), 32'd3);
    chk("bp_rx0", (rx.size() > 0) ? 32'(rx[0]) : 32'hFFFF_FFFF, 32'h10);
    chk("bp_rx1", (rx.size() > 1) ? 32'(rx[1]) : 32'hFFFF_FFFF, 32'h11);
    chk("bp_rx2", (rx.size() > 2) ? 32'(rx[2]) : 32'hFFFF_FFFF, 32'h12);

    // Early release by requester 3 while requester 0 waits
    bus.ReqValid = 4'b1000; bus.OutReady = 1'b1;
    do_reset();
    glog.delete();
    @(posedge clk); #1;
    bus.ReqValid = 4'b1001;
    repeat (2) @(posedge clk); #1;
    bus.ReqValid = 4'b0001;
    @(posedge clk); #1;
    @(negedge clk);
    chk("early_idle_busy", 32'(bus.Busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("early_grant_s",    32'(bus.S),    32'd0);
    chk("early_grant_busy", 32'(bus.Busy), 32'd1);
    chk("early_first_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF_FFFF, 32'd3);
    @(posedge clk); #1;
    bus.ReqValid = 4'b0000;
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of a burst to requester 2 after the pointer has moved
    bus.ReqValid = 4'b0010; bus.OutReady = 1'b1;
    do_reset();
    @(posedge clk); #1;
    bus.ReqValid = 4'b0100;
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    chk("abort_pre_out_valid", 32'(bus.OutValid), 32'd1);
    chk("abort_pre_s",         32'(bus.S),        32'd2);
    rst = 1'b1; bus.ReqValid = 4'b1011;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(bus.OutValid), 32'd0);
    chk("abort_s",         32'(bus.S),        32'd0);
    chk("abort_busy",      32'(bus.Busy),     32'd0);
    chk("abort_out",       32'(bus.Out),      32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_regrant_s",    32'(bus.S),    32'd0);
    chk("abort_regrant_busy", 32'(bus.Busy), 32'd1);
    @(posedge clk); #1;
    bus.ReqValid = 4'b0000;
    repeat (8) @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
